// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with tick strobes
// Optional single-step mode is built in when CLKDIV_STEP_EN is defined.
module clk_div_multi #(
  parameter int CNT_W       = 32,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int DEFAULT_DIV = 300000000
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic              cfg_err,
  input  logic              step_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic [CNT_W-1:0]  div_reg [NUM_CH];
  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [NUM_CH-1:0] mode_reg;
  logic              accept;
  logic              ch_bad;
  logic              step_edge;
  logic              mode_new;

  assign accept = cfg_valid && cfg_ready;
  assign ch_bad = {1'b0, cfg_ch} >= NUM_CH_L;

`ifdef CLKDIV_STEP_EN
  logic step_prev;

  // History updates every cycle, even when a same-channel config swallows the step.
  always_ff @(posedge clk_in) begin
    if (reset) step_prev <= 1'b0;
    else       step_prev <= step_req;
  end

  assign step_edge = step_req && !step_prev;
  assign mode_new  = cfg_mode;
`else
  logic unused_ok;

  assign unused_ok = ^{cfg_mode, step_req};
  assign step_edge = 1'b0;
  assign mode_new  = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      clk_out   <= '0;
      tick      <= '0;
      mode_reg  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_reg[i] <= DIV_RST;
        cnt[i]     <= '0;
      end
    end else begin
      cfg_ready <= !accept;
      cfg_err   <= accept && ch_bad;
      for (int i = 0; i < NUM_CH; i++) begin
        tick[i] <= 1'b0;
        if (accept && !ch_bad && cfg_ch == CH_W'(i)) begin
          div_reg[i]  <= cfg_div;
          mode_reg[i] <= mode_new;
          cnt[i]      <= '0;
        end else if (mode_reg[i]) begin
          cnt[i] <= '0;
          if (step_edge) begin
            clk_out[i] <= !clk_out[i];
            tick[i]    <= 1'b1;
          end
        end else if (run) begin
          // >= rather than == so an out-of-range count still wraps.
          if (cnt[i] >= div_reg[i]) begin
            cnt[i]     <= '0;
            clk_out[i] <= !clk_out[i];
            tick[i]    <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
// Step-mode checks are compiled in when CLKDIV_STEP_EN is defined.
module tb_clk_div_multi;

  localparam int CNT_W  = 32;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 3;
  localparam int DEF    = 300000000;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              run;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic              cfg_err;
  logic              step_req;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_a;
  int cnt_b;

  clk_div_multi #(
    .CNT_W(CNT_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .DEFAULT_DIV(DEF)
  ) dut (
    .clk_in(clk_in), .reset(reset), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
    .step_req(step_req), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_mode  = 1'b0;
    step_req  = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic cfg(input int ch, input int div, input logic mode);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = CNT_W'(div);
    cfg_mode  = mode;
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    // Reset values and ch0 D=3
    do_reset();
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_cfg_err", cfg_err, 0);
    run = 1'b1;
    cfg(0, 3, 1'b0);
    check("t1_ready_drop", cfg_ready, 0);
    check("t1_no_tick_on_cfg", tick[0], 0);
    for (int n = 1; n <= 24; n++) begin
      cyc();
      check($sformatf("t1_tick0_n%0d", n), tick[0], (n % 4 == 0));
      check($sformatf("t1_clk0_n%0d", n), clk_out[0], (n / 4) % 2);
      check($sformatf("t1_others_n%0d", n), {clk_out[3:1], tick[3:1]}, 0);
    end
    cnt_a = 0;
    cnt_b = 0;
    for (int n = 0; n < 1000; n++) begin
      cyc();
      if (tick[0]) cnt_a++;
      if (tick[3:1] != 0 || clk_out[3:1] != 0) cnt_b++;
    end
    check("t1_ch0_ticks_1000", cnt_a, 250);
    check("t1_others_idle_1000", cnt_b, 0);

    // Back-to-back config: ch1 D=0 then ch2 D=5 with cfg_valid held
    do_reset();
    run       = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd1;
    cfg_div   = 0;
    cfg_mode  = 1'b0;
    cyc();
    check("t2_ready_low_1", cfg_ready, 0);
    cfg_ch  = 3'd2;
    cfg_div = 5;
    cyc();
    check("t2_ready_back", cfg_ready, 1);
    check("t2_clk1_first", clk_out[1], 1);
    check("t2_tick1_first", tick[1], 1);
    cyc();
    cfg_valid = 1'b0;
    check("t2_ready_low_2", cfg_ready, 0);
    check("t2_clk1_second", clk_out[1], 0);
    for (int n = 1; n <= 12; n++) begin
      cyc();
      check($sformatf("t2_tick1_n%0d", n), tick[1], 1);
      check($sformatf("t2_clk1_n%0d", n), clk_out[1], n % 2);
      check($sformatf("t2_tick2_n%0d", n), tick[2], (n % 6 == 0));
      check($sformatf("t2_clk2_n%0d", n), clk_out[2], (n >= 6 && n < 12));
    end

    // Pause with run=0 and resume with remaining count
    do_reset();
    run = 1'b1;
    cfg(0, 9, 1'b0);
    repeat (7) cyc();
    run   = 1'b0;
    cnt_a = 0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (tick[0] || clk_out[0]) cnt_a++;
    end
    check("t3_frozen", cnt_a, 0);
    run = 1'b1;
    cyc();
    cyc();
    check("t3_resume_no_tick", tick[0], 0);
    check("t3_resume_clk0", clk_out[0], 0);
    cyc();
    check("t3_resume_tick", tick[0], 1);
    check("t3_resume_clk1", clk_out[0], 1);
    cnt_a = 0;
    repeat (9) begin
      cyc();
      if (tick[0]) cnt_a++;
    end
    check("t3_gap_no_tick", cnt_a, 0);
    cyc();
    check("t3_next_tick", tick[0], 1);
    check("t3_next_clk", clk_out[0], 0);

    // Out-of-range channel
    do_reset();
    run = 1'b1;
    cfg(5, 2, 1'b0);
    check("t4_err_pulse", cfg_err, 1);
    check("t4_ready_low", cfg_ready, 0);
    cyc();
    check("t4_err_clear", cfg_err, 0);
    check("t4_ready_back", cfg_ready, 1);
    for (int i = 0; i < NUM_CH; i++) check($sformatf("t4_div_%0d", i), dut.div_reg[i], DEF);
    cnt_a = 0;
    repeat (10) begin
      cyc();
      if (tick != 0 || cfg_err) cnt_a++;
    end
    check("t4_quiet", cnt_a, 0);

`ifdef CLKDIV_STEP_EN
    // Single-step mode on ch0
    do_reset();
    run = 1'b1;
    cfg(0, 3, 1'b1);
    for (int s = 1; s <= 3; s++) begin
      step_req = 1'b1;
      cyc();
      check($sformatf("t5_step_tick_%0d", s), tick[0], 1);
      check($sformatf("t5_step_clk_%0d", s), clk_out[0], s % 2);
      step_req = 1'b0;
      cyc();
      check($sformatf("t5_step_idle_%0d", s), tick[0], 0);
    end
    step_req = 1'b1;
    cyc();
    check("t5_hold_first", clk_out[0], 0);
    cnt_a = 0;
    repeat (9) begin
      cyc();
      if (tick[0]) cnt_a++;
    end
    check("t5_hold_no_more", cnt_a, 0);
    check("t5_hold_clk", clk_out[0], 0);
    step_req = 1'b0;
    cyc();
    step_req  = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd0;
    cfg_div   = 3;
    cfg_mode  = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    check("t5_cfg_blocks_step", tick[0], 0);
    check("t5_cfg_blocks_clk", clk_out[0], 0);
    cyc();
    check("t5_history_updated", tick[0], 0);
    step_req = 1'b0;
    cyc();
    step_req = 1'b1;
    cyc();
    check("t5_step_after_cfg", tick[0], 1);
    check("t5_step_after_cfg_clk", clk_out[0], 1);
    step_req = 1'b0;
`else
    // Without step support cfg_mode is ignored: ch0 free-runs
    do_reset();
    run = 1'b1;
    step_req = 1'b1;
    cfg(0, 1, 1'b1);
    cyc();
    check("t5_freerun_wait", tick[0], 0);
    cyc();
    check("t5_freerun_tick", tick[0], 1);
    check("t5_freerun_clk", clk_out[0], 1);
    step_req = 1'b0;
`endif

    // Reset mid-count with a pending config
    do_reset();
    run = 1'b1;
    cfg(0, 7, 1'b0);
    repeat (12) cyc();
    check("t6_pre_clk", clk_out[0], 1);
    reset     = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd0;
    cfg_div   = 2;
    cyc();
    check("t6_clk_out", clk_out, 0);
    check("t6_tick", tick, 0);
    check("t6_div_default", dut.div_reg[0], DEF);
    check("t6_ready_not_accepted", cfg_ready, 1);
    check("t6_err", cfg_err, 0);
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cyc();
    check("t6_after_clk", clk_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider for the 8085 board. Generates NUM_CH independent divided clocks and matching one-cycle tick strobes from clk_in. Each channel's divisor and mode are programmable at runtime through a valid/ready port. A single-step mode lets the CPU clock be advanced one edge at a time from a push-button or debug controller.

## Interface
- CNT_W, 32: width of divisor and per-channel counter.
- NUM_CH, 4: number of output channels, 1..2**CH_W.
- CH_W, 2: width of cfg_ch.
- DEFAULT_DIV, 300000000: divisor loaded into every channel at reset; must fit in CNT_W bits.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  global enable for free-running channels; 0 freezes counters and outputs.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  block can accept config this cycle.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  CNT_W  new divisor D.
- cfg_mode  in  1  0 = free-run, 1 = single-step (CLKDIV_STEP_EN only).
- cfg_err  out  1  one-cycle pulse: accepted config had cfg_ch >= NUM_CH.
- step_req  in  1  synchronous step request; rising edge = one step.
- clk_out  out  NUM_CH  divided clocks, one bit per channel.
- tick  out  NUM_CH  one-cycle strobe on every clk_out toggle.

## Operation
- Per channel: div_reg (CNT_W), mode_reg (1 bit), cnt (CNT_W).
- Free-run, run=1: if cnt == div_reg then cnt <= 0, clk_out toggles, tick = 1; else cnt <= cnt + 1, tick = 0.
- Half period = D+1 cycles, full period = 2(D+1). D = 0 toggles every cycle.
- run=0: cnt and clk_out hold, tick = 0.
- Step mode: cnt is held at 0. A step_req rising edge (step_req=1, previous sample 0) toggles clk_out and pulses tick on every step-mode channel. run is ignored.
- Config accept: cfg_valid && cfg_ready.
  - Valid channel: div_reg <= cfg_div, mode_reg <= cfg_mode, cnt <= 0. clk_out holds; no tick that cycle.
  - cfg_ch >= NUM_CH: nothing is written; cfg_err pulses for one cycle.
- cfg_ready drops for exactly one cycle after each accept, then returns to 1. Back-to-back configs therefore take at least 2 cycles each.
- Priority, high to low: reset > config accept on that channel > step edge > count.
- Counter wrap: cnt never exceeds div_reg.
  - If a new divisor is written while cnt is above it, the write clears cnt anyway.
  - If cnt somehow exceeds div_reg, it is treated as a terminal count: toggle, then cnt <= 0.

## Timing
- Reset values: clk_out = 0, tick = 0, cfg_ready = 1, cfg_err = 0, cnt = 0, div_reg = DEFAULT_DIV, mode_reg = 0, step history = 0.
- Reset applied mid-operation takes effect on the next clk_in edge and discards any pending config.
- All outputs are registered. tick is high in the same cycle that clk_out shows its new value.
- Free-run latency: after a config accept at edge k, the first toggle is at edge k+D+1.
- Step latency: step_req first sampled high at edge k gives a toggle visible after edge k. Holding step_req high produces no further steps.
- The step edge detector updates every cycle, including cycles in which the step is dropped by a same-channel config.

## Configuration
- CLKDIV_STEP_EN defined: single-step mode and step_req logic are implemented as described.
- CLKDIV_STEP_EN undefined:
  - cfg_mode is ignored and mode_reg is constant 0.
  - step_req is unused.
  - All channels are free-run only.
  - All other behaviour is identical.

## Test plan
- Reset, run=1, config ch0 D=3: clk_out[0] toggles every 4 cycles (period 8); tick[0] pulses on each toggle; other channels stay at DEFAULT_DIV with no toggle within 1000 cycles.
- Config ch1 D=0, then ch2 D=5 back-to-back with cfg_valid held: cfg_ready low one cycle between accepts; ch1 toggles every cycle, ch2 every 6 cycles.
- ch0 D=9 running, run=0 for 20 cycles, then run=1: clk_out[0] and cnt are frozen during the pause and resume with the remaining count intact.
- cfg_ch=5 with NUM_CH=4: cfg_err pulses once; no div_reg changes; cfg_ready low one cycle.
- (CLKDIV_STEP_EN) ch0 mode=1: three step_req pulses give three toggles with 1-cycle latency each; step_req held high for 10 cycles gives only one toggle; a step and a ch0 config in the same cycle give no toggle.
- Assert reset mid-count with ch0 D=7 at cnt=4: the next cycle shows clk_out=0 and div_reg=DEFAULT_DIV; a pending cfg_valid is not accepted during reset.
